nibble_serial_subtractor: RTL

- Multi-cycle subtractor: computes D = A - B - Bin on WIDTH-bit operands, one 4-bit slice per clock.
- Subtraction is done as addition in two's complement: A + ~B + ~Bin.
- A registered carry links each slice to the next.
- Sits beside the 4-bit carry-lookahead adder as the inverse arithmetic datapath.
- Start/busy/done handshake, for area-constrained control paths.

---
 rtl/nibble_serial_subtractor_if.sv | 26 ++
 rtl/nibble_serial_subtractor.sv | 117 +++++++++++
 2 files changed

// File: rtl/nibble_serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bundle for the nibble-serial subtractor.
// The master drives the request and operands; the slave returns the status and the result.
interface nibble_serial_subtractor_if #(
   parameter int unsigned WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] D;
   logic             Bout;
   logic             V;
   logic             Z;

   modport master (
      output start, A, B, Bin,
      input  busy, done, D, Bout, V, Z
   );

   modport slave (
      input  start, A, B, Bin,
      output busy, done, D, Bout, V, Z
   );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: D = A - B - Bin computed as A + ~B + ~Bin, one 4-bit slice per clock,
// with a registered carry linking each slice to the next.
module nibble_serial_subtractor #(
   parameter int unsigned WIDTH = 16
) (
   input logic                          clk,
   input logic                          rst,
   nibble_serial_subtractor_if.slave    bus
);
   localparam int unsigned NIB  = WIDTH / 4;
   localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             bout_q, bout_d;
   logic             v_q, v_d;
   logic             z_q, z_d;

   logic [3:0]       a_nib;
   logic [3:0]       b_nib;
   logic [4:0]       sum5;
   logic [WIDTH-1:0] acc_upd;
   logic             last_slice;

   // Slice datapath: partial results collect in acc_q so D only changes on the done edge.
   always_comb begin
      a_nib      = a_q[{idx_q, 2'b00} +: 4];
      b_nib      = b_q[{idx_q, 2'b00} +: 4];
      sum5       = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'b0000, carry_q};
      acc_upd    = acc_q;
      acc_upd[{idx_q, 2'b00} +: 4] = sum5[3:0];
      last_slice = (idx_q == IDXW'(NIB - 1));
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      d_d     = d_q;
      bout_d  = bout_q;
      v_d     = v_q;
      z_d     = z_q;

      case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               state_d = StRun;
               a_d     = bus.A;
               b_d     = bus.B;
               carry_d = ~bus.Bin;
               idx_d   = '0;
               acc_d   = '0;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            carry_d = sum5[4];
            acc_d   = acc_upd;
            idx_d   = idx_q + 1'b1;
            if (last_slice) begin
               state_d = StDone;
               idx_d   = '0;
               d_d     = acc_upd;
               bout_d  = ~sum5[4];
               v_d     = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (acc_upd[WIDTH-1] != a_q[WIDTH-1]);
               z_d     = (acc_upd == '0);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         d_q     <= '0;
         bout_q  <= 1'b0;
         v_q     <= 1'b0;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         d_q     <= d_d;
         bout_q  <= bout_d;
         v_q     <= v_d;
         z_q     <= z_d;
      end
   end

   assign bus.busy = (state_q == StRun);
   assign bus.done = (state_q == StDone);
   assign bus.D    = d_q;
   assign bus.Bout = bout_q;
   assign bus.V    = v_q;
   assign bus.Z    = z_q;

endmodule
